// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared constants, stage state encoding and helpers for the 4-way round-robin mux arbiter.
package rr_mux4_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  // Output stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_st_t;

  // Requester index to one-hot grant vector
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first requester set when searching last+1, last+2, last+3, last.
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk the rotated order once; the first hit is kept
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4x1 mux into a single-entry valid/ready output stage.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   select,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready
);

  stage_st_t        st_q, st_d;
  logic [IDX_W-1:0] last_q;
  logic             lock_active_q;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] win_idx;
  logic             can_load;
  logic             lock_hold;
  logic             accept;
  logic [WIDTH-1:0] mux_word;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbitration, grant pulse and stage next-state
  always_comb begin
    st_d      = st_q;
    gnt       = '0;
    win_idx   = pick_idx;
    can_load  = (st_q == ST_EMPTY) || out_ready;
    lock_hold = lock_active_q && req[last_q];
    accept    = can_load && pick_found;
    if (lock_hold) begin
      win_idx = last_q;
    end
    if (accept) begin
      gnt  = idx_to_onehot(win_idx);
      st_d = ST_FULL;
    end else if (can_load) begin
      st_d = ST_EMPTY;
    end
  end

  // Shared 4x1 data mux steered by the winner
  always_comb begin
    case (win_idx)
      2'd0:    mux_word = in0;
      2'd1:    mux_word = in1;
      2'd2:    mux_word = in2;
      default: mux_word = in3;
    endcase
  end

  // Stage state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  // Output word, select, round-robin pointer and burst lock
  always_ff @(posedge clk) begin
    if (rst) begin
      out           <= '0;
      select        <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      lock_active_q <= 1'b0;
    end else if (accept) begin
      out           <= mux_word;
      select        <= win_idx;
      last_q        <= win_idx;
      lock_active_q <= lock[win_idx];
    end else if (lock_active_q && !req[last_q]) begin
      lock_active_q <= 1'b0;
    end
  end

  assign out_valid = (st_q == ST_FULL);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: directed vector table, hand-written lock/reset sequences, random traffic vs model.
module tb_rr_mux4_arbiter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   gnt;
  logic [1:0]   select;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  rr_mux4_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .select    (select),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: stage contents, pointer, burst lock
  logic         m_valid;
  logic [1:0]   m_sel;
  logic [W-1:0] m_out;
  int           m_last;
  logic         m_lock;

  typedef struct {
    logic            rs;
    logic [3:0]      r;
    logic [3:0]      l;
    logic            rdy;
    logic [3:0][W-1:0] d;
    logic [3:0]      eg;
    logic            ev;
    logic [1:0]      es;
    logic [W-1:0]    eo;
    logic            cd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_sel   = 2'd0;
    m_out   = '0;
    m_last  = 3;
    m_lock  = 1'b0;
  endfunction

  // Winner index by the arbitration rules, -1 when nothing is granted
  function automatic int model_pick(input logic [3:0] r, input logic rdy);
    int w;
    w = -1;
    if ((!m_valid || rdy) && r != 4'd0) begin
      if (m_lock && r[m_last]) begin
        w = m_last;
      end else begin
        for (int off = 1; off <= 4; off++) begin
          int k;
          k = (m_last + off) % 4;
          if (w < 0 && r[k]) w = k;
        end
      end
    end
    return w;
  endfunction

  // One clock: drive at negedge, check gnt, then check registered outputs after the edge
  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] l, input logic rdy,
                      input logic [3:0][W-1:0] d, output logic [3:0] g_seen);
    int w;
    logic [3:0] exp_g;
    @(negedge clk);
    rst = rs; req = r; lock = l; out_ready = rdy;
    in0 = d[0]; in1 = d[1]; in2 = d[2]; in3 = d[3];
    #1;
    w = model_pick(r, rdy);
    exp_g = (w < 0) ? 4'd0 : (4'd1 << w);
    if (!rs) chk("model_gnt", W'(gnt), W'(exp_g));
    g_seen = gnt;
    @(posedge clk);
    #1;
    if (rs) begin
      model_reset();
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_out   = d[w];
      m_sel   = 2'(w);
      m_last  = w;
      m_lock  = l[w];
    end else begin
      if (!m_valid || rdy) m_valid = 1'b0;
      if (m_lock && !r[m_last]) m_lock = 1'b0;
    end
    chk("model_out_valid", W'(out_valid), W'(m_valid));
    if (m_valid) begin
      chk("model_select", W'(select), W'(m_sel));
      chk("model_out", out, m_out);
    end
  endtask

  task automatic add(input logic rs, input logic [3:0] r, input logic [3:0] l, input logic rdy,
                     input logic [3:0][W-1:0] d, input logic [3:0] eg, input logic ev,
                     input logic [1:0] es, input logic [W-1:0] eo, input logic cd);
    vec_t v;
    v.rs = rs; v.r = r; v.l = l; v.rdy = rdy; v.d = d;
    v.eg = eg; v.ev = ev; v.es = es; v.eo = eo; v.cd = cd;
    tbl.push_back(v);
  endtask

  logic [3:0][W-1:0] dz, ds, drr, dbp, pd;
  logic [3:0] g, pending, lk;
  logic rdy, rs;

  initial begin
    rst = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    dz = '0;
    ds = '0;  ds[2] = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) drr[k] = W'(k + 1);
    dbp = '0; dbp[0] = 32'hA0A0A0A0; dbp[1] = 32'hB1B1B1B1;

    // Reset and idle
    add(1, 4'b0000, 4'b0, 1, dz, 4'b0000, 0, 0, 0, 1);
    add(1, 4'b0000, 4'b0, 1, dz, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 4'b0, 1, dz, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 4'b0, 1, dz, 4'b0000, 0, 0, 0, 1);
    // Single requester
    add(0, 4'b0100, 4'b0, 1, ds, 4'b0100, 1, 2, 32'hDEADBEEF, 1);
    add(0, 4'b0000, 4'b0, 1, ds, 4'b0000, 0, 0, 0, 0);
    // Round-robin fairness, no bubbles
    add(1, 4'b0000, 4'b0, 1, drr, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b1111, 4'b0, 1, drr, 4'b0001, 1, 0, 1, 1);
    add(0, 4'b1111, 4'b0, 1, drr, 4'b0010, 1, 1, 2, 1);
    add(0, 4'b1111, 4'b0, 1, drr, 4'b0100, 1, 2, 3, 1);
    add(0, 4'b1111, 4'b0, 1, drr, 4'b1000, 1, 3, 4, 1);
    add(0, 4'b1111, 4'b0, 1, drr, 4'b0001, 1, 0, 1, 1);
    add(0, 4'b0000, 4'b0, 1, drr, 4'b0000, 0, 0, 0, 0);
    // Backpressure, then drain-and-refill in one cycle
    add(1, 4'b0000, 4'b0, 1, dbp, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0011, 4'b0, 1, dbp, 4'b0001, 1, 0, 32'hA0A0A0A0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0011, 4'b0, 0, dbp, 4'b0000, 1, 0, 32'hA0A0A0A0, 1);
    add(0, 4'b0011, 4'b0, 1, dbp, 4'b0010, 1, 1, 32'hB1B1B1B1, 1);
    add(0, 4'b0000, 4'b0, 1, dbp, 4'b0000, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].r, tbl[i].l, tbl[i].rdy, tbl[i].d, g);
      chk($sformatf("v%0d_gnt", i), W'(g), W'(tbl[i].eg));
      chk($sformatf("v%0d_out_valid", i), W'(out_valid), W'(tbl[i].ev));
      if (tbl[i].cd) begin
        chk($sformatf("v%0d_select", i), W'(select), W'(tbl[i].es));
        chk($sformatf("v%0d_out", i), out, tbl[i].eo);
      end
    end

    // Lock burst: requester 0 keeps the grant while locked, then 3 gets its turn
    step(1, 4'b0000, 4'b0000, 1, drr, g);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1001, 4'b0001, 1, drr, g);
      chk($sformatf("lock%0d_gnt", i), W'(g), W'(4'b0001));
      chk($sformatf("lock%0d_out", i), out, W'(1));
    end
    step(0, 4'b1000, 4'b0000, 1, drr, g);
    chk("lock_release_gnt", W'(g), W'(4'b1000));
    chk("lock_release_select", W'(select), W'(3));
    chk("lock_release_out", out, W'(4));

    // Reset mid-burst while stalled and locked
    step(0, 4'b1111, 4'b0001, 1, drr, g);
    chk("rstmid_first_gnt", W'(g), W'(4'b0001));
    step(1, 4'b0000, 4'b0000, 0, drr, g);
    chk("rstmid_out_valid", W'(out_valid), W'(0));
    step(0, 4'b0000, 4'b0000, 1, drr, g);
    chk("rstmid_idle_gnt", W'(g), W'(4'b0000));
    chk("rstmid_idle_valid", W'(out_valid), W'(0));
    step(0, 4'b1111, 4'b0000, 1, drr, g);
    chk("rstmid_regrant", W'(g), W'(4'b0001));
    chk("rstmid_regrant_out", out, W'(1));

    // Random traffic: requests held with stable data until granted
    pending = '0; pd = '0; lk = '0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 149) == 0);
      if (!(m_valid && !rdy)) begin
        for (int k = 0; k < 4; k++) begin
          if (!pending[k] && $urandom_range(0, 2) == 0) begin
            pending[k] = 1'b1;
            pd[k] = W'($urandom);
          end
        end
        lk = 4'($urandom) & 4'($urandom);
      end
      step(rs, pending, lk, rdy, pd, g);
      if (!rs) pending = pending & ~g;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
